result_issuer: RTL and testbench

- Upstream stage of the 5-bit result demultiplexer; produces its `res` code and `enable` strobe.
- Accepts result codes from the datapath over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues each code to the demux as a framed transaction: `res` is held stable and `enable` is asserted for HOLD cycles, followed by one guard cycle. This lets the demux outputs settle back to high-Z between codes.

---
 rtl/result_pkg.sv | 16 +
 rtl/result_fifo.sv | 59 +++++
 rtl/result_issuer.sv | 112 +++++++++++
 tb/tb_result_issuer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared definitions for the result issue path and the demux it feeds.
// Code width, FSM encoding and the named result codes live here.
package result_pkg;

    localparam int RES_SIZE = 5;

    localparam logic [RES_SIZE-1:0] CODE_ONE   = 5'd1;
    localparam logic [RES_SIZE-1:0] CODE_THREE = 5'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Small power-of-two FIFO holding result codes waiting to be issued.
// Read data is the current head; level is a registered occupancy count.
module result_fifo #(
    parameter int SIZE  = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [SIZE-1:0]          wdata,
    output logic [SIZE-1:0]          rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            wr;
    logic            rd;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            if (wr && !rd) begin
                level <= level + (AW+1)'(1);
            end else if (rd && !wr) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/result_issuer.sv
// Buffers result codes and issues each as an enable-framed transaction
// to the result demux, with a guard cycle so its outputs can settle.
module result_issuer
    import result_pkg::*;
#(
    parameter int SIZE  = RES_SIZE,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIZE-1:0]          in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SIZE-1:0]          res,
    output logic                     enable,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [SIZE-1:0] res_q;
    logic [SIZE-1:0] res_d;
    logic            en_q;
    logic            en_d;
    logic            pop;
    logic            push;
    logic            full;
    logic            empty;
    logic [SIZE-1:0] head;

    // Readiness comes from the registered level only: no push-through when full.
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign res      = res_q;
    assign enable   = en_q;
    assign busy     = (state_q != IDLE);

    result_fifo #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        en_d    = en_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                res_d = '0;
                en_d  = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    res_d   = head;
                    en_d    = 1'b1;
                    cnt_d   = CW'(HOLD - 1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                res_d   = '0;
                en_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                res_d   = '0;
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_issuer.sv
// Bench for result_issuer: vector table, scoreboard monitors, corner sequences.
// A HOLD=1 instance runs alongside the default HOLD=2 instance.
module tb_result_issuer;

    logic       clk;
    logic       rst_n;
    logic [4:0] data;
    logic       valid;
    logic       ready;
    logic [4:0] res;
    logic       en;
    logic       busy;
    logic [2:0] lvl;
    logic [4:0] data1;
    logic       valid1;
    logic       ready1;
    logic [4:0] res1;
    logic       en1;
    logic       busy1;
    logic [2:0] lvl1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] cur0 = '0;
    logic [4:0] cur1 = '0;
    logic       pen0 = 1'b0;
    logic       pen1 = 1'b0;
    int         run0 = 0;
    int         run1 = 0;
    int         issued0 = 0;
    int         issued1 = 0;

    typedef struct {
        logic [4:0] d;
        logic       v;
        logic       rdy;
        logic [2:0] lvl;
        logic [4:0] res;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t tbl[22];

    result_issuer #(.SIZE(5), .DEPTH(4), .HOLD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (data),
        .in_valid (valid),
        .in_ready (ready),
        .res      (res),
        .enable   (en),
        .busy     (busy),
        .level    (lvl)
    );

    result_issuer #(.SIZE(5), .DEPTH(4), .HOLD(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (data1),
        .in_valid (valid1),
        .in_ready (ready1),
        .res      (res1),
        .enable   (en1),
        .busy     (busy1),
        .level    (lvl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, HOLD=2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pen0 = 1'b0;
            run0 = 0;
        end else begin
            if (en && !pen0) begin
                issued0++;
                if (q0.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb0_empty: got res=%0d expected no issue", res);
                end else begin
                    cur0 = q0.pop_front();
                    chk("sb0_order", int'(res), int'(cur0));
                end
            end
            if (en) run0++;
            if (!en && pen0) begin
                chk("sb0_hold_len", run0, 2);
                chk("sb0_gap_res", int'(res), int'(cur0));
                run0 = 0;
            end
            pen0 = en;
        end
    end

    // Scoreboard monitor, HOLD=1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pen1 = 1'b0;
            run1 = 0;
        end else begin
            if (en1 && !pen1) begin
                issued1++;
                if (q1.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb1_empty: got res=%0d expected no issue", res1);
                end else begin
                    cur1 = q1.pop_front();
                    chk("sb1_order", int'(res1), int'(cur1));
                end
            end
            if (en1) run1++;
            if (!en1 && pen1) begin
                chk("sb1_hold_len", run1, 1);
                chk("sb1_gap_res", int'(res1), int'(cur1));
                run1 = 0;
            end
            pen1 = en1;
        end
    end

    task automatic chk_all(input string n, input vec_t e);
        chk({n, "_rdy"}, int'(ready), int'(e.rdy));
        chk({n, "_lvl"}, int'(lvl), int'(e.lvl));
        chk({n, "_res"}, int'(res), int'(e.res));
        chk({n, "_en"}, int'(en), int'(e.en));
        chk({n, "_busy"}, int'(busy), int'(e.busy));
    endtask

    initial begin
        int acc;
        int cyc;
        logic [4:0] codes1[4];

        // d, v, rdy, lvl, res, en, busy (outputs after the edge)
        tbl[0]  = '{5'd1,  1'b1, 1'b1, 3'd1, 5'd0,  1'b0, 1'b0};
        tbl[1]  = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd1,  1'b1, 1'b1};
        tbl[2]  = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd1,  1'b1, 1'b1};
        tbl[3]  = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd1,  1'b0, 1'b1};
        tbl[4]  = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd0,  1'b0, 1'b0};
        tbl[5]  = '{5'd1,  1'b1, 1'b1, 3'd1, 5'd0,  1'b0, 1'b0};
        tbl[6]  = '{5'd3,  1'b1, 1'b1, 3'd1, 5'd1,  1'b1, 1'b1};
        tbl[7]  = '{5'd7,  1'b1, 1'b1, 3'd2, 5'd1,  1'b1, 1'b1};
        tbl[8]  = '{5'd31, 1'b1, 1'b1, 3'd3, 5'd1,  1'b0, 1'b1};
        tbl[9]  = '{5'd0,  1'b0, 1'b1, 3'd3, 5'd0,  1'b0, 1'b0};
        tbl[10] = '{5'd0,  1'b0, 1'b1, 3'd2, 5'd3,  1'b1, 1'b1};
        tbl[11] = '{5'd0,  1'b0, 1'b1, 3'd2, 5'd3,  1'b1, 1'b1};
        tbl[12] = '{5'd0,  1'b0, 1'b1, 3'd2, 5'd3,  1'b0, 1'b1};
        tbl[13] = '{5'd0,  1'b0, 1'b1, 3'd2, 5'd0,  1'b0, 1'b0};
        tbl[14] = '{5'd0,  1'b0, 1'b1, 3'd1, 5'd7,  1'b1, 1'b1};
        tbl[15] = '{5'd0,  1'b0, 1'b1, 3'd1, 5'd7,  1'b1, 1'b1};
        tbl[16] = '{5'd0,  1'b0, 1'b1, 3'd1, 5'd7,  1'b0, 1'b1};
        tbl[17] = '{5'd0,  1'b0, 1'b1, 3'd1, 5'd0,  1'b0, 1'b0};
        tbl[18] = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd31, 1'b1, 1'b1};
        tbl[19] = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd31, 1'b1, 1'b1};
        tbl[20] = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd31, 1'b0, 1'b1};
        tbl[21] = '{5'd0,  1'b0, 1'b1, 3'd0, 5'd0,  1'b0, 1'b0};

        rst_n  = 1'b0;
        data   = '0;
        valid  = 1'b0;
        data1  = '0;
        valid1 = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", '{5'd0, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);

        // Single push then four back-to-back pushes, cycle by cycle.
        for (int i = 0; i < 22; i++) begin
            data  = tbl[i].d;
            valid = tbl[i].v;
            if (valid && ready) q0.push_back(data);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end
        valid = 1'b0;

        // Continuous valid: fill to full, blocked push while full, late accept.
        acc = 0;
        cyc = 0;
        valid = 1'b1;
        while (acc < 5 && cyc < 20) begin
            data = 5'(10 + acc);
            if (ready) begin
                q0.push_back(data);
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("fill_count", acc, 5);
        chk("full_lvl", int'(lvl), 4);
        chk("full_rdy", int'(ready), 0);
        data = 5'd15;
        @(negedge clk);
        chk("pop_full_lvl", int'(lvl), 3);
        chk("pop_full_rdy", int'(ready), 1);
        q0.push_back(data);
        @(negedge clk);
        valid = 1'b0;
        chk("late_push_lvl", int'(lvl), 4);
        cyc = 0;
        while ((q0.size() != 0 || busy || lvl != 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain0_left", q0.size(), 0);
        chk("drain0_busy", int'(busy), 0);
        chk("issued0", issued0, 11);

        // Asynchronous reset in the second ISSUE cycle of code 3.
        data  = 5'd1;
        valid = 1'b1;
        q0.push_back(data);
        @(negedge clk);
        data = 5'd3;
        q0.push_back(data);
        @(negedge clk);
        valid = 1'b0;
        cyc = 0;
        while (!(en && res == 5'd3) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_code3", int'(en && res == 5'd3), 1);
        @(posedge clk);
        #2;
        chk("rst_pre_en", int'(en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", int'(en), 0);
        chk("rst_async_res", int'(res), 0);
        chk("rst_async_lvl", int'(lvl), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_rdy", int'(ready), 1);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_en", int'(en), 0);
            chk("post_rst_lvl", int'(lvl), 0);
        end
        chk("issued0_rst", issued0, 13);

        // HOLD=1 instance: code 0 framed as one enable cycle plus a gap.
        data1  = 5'd0;
        valid1 = 1'b1;
        q1.push_back(data1);
        @(negedge clk);
        valid1 = 1'b0;
        chk("h1_lvl", int'(lvl1), 1);
        chk("h1_idle_en", int'(en1), 0);
        @(negedge clk);
        chk("h1_issue_en", int'(en1), 1);
        chk("h1_issue_res", int'(res1), 0);
        chk("h1_issue_busy", int'(busy1), 1);
        @(negedge clk);
        chk("h1_gap_en", int'(en1), 0);
        chk("h1_gap_busy", int'(busy1), 1);
        @(negedge clk);
        chk("h1_idle_busy", int'(busy1), 0);
        codes1[0] = 5'd5;
        codes1[1] = 5'd31;
        codes1[2] = 5'd0;
        codes1[3] = 5'd3;
        for (int i = 0; i < 4; i++) begin
            data1  = codes1[i];
            valid1 = 1'b1;
            if (ready1) q1.push_back(data1);
            @(negedge clk);
        end
        valid1 = 1'b0;
        cyc = 0;
        while ((q1.size() != 0 || busy1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain1_left", q1.size(), 0);
        chk("issued1", issued1, 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
